// File: rtl/wb_gain_calc.sv
// White-balance gain calculator: derives a target level from channel means and
// divides it by each mean with one shared restoring divider, one channel at a time.
module wb_gain_calc #(
    parameter int DW     = 8,
    parameter int CH     = 3,
    parameter int FRAC   = 8,
    parameter int GW     = 16,
    parameter int REF_CH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [CH*DW-1:0] mean_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [CH*GW-1:0] gain_o,
    output logic [CH-1:0]    zero_o,
    output logic [CH-1:0]    sat_o
);

    localparam int Q  = DW + FRAC;
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam int CW = $clog2(Q);
    localparam int SW = DW + $clog2(CH) + 1;
    localparam int QX = Q + GW;
    localparam logic [GW-1:0] ONE  = GW'(1) << FRAC;
    localparam logic [GW-1:0] GMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TGT,
        S_DIV,
        S_STORE,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               mode_q;
    logic [CH*DW-1:0]   mean_q;
    logic [DW-1:0]      tgt_q;
    logic [IW-1:0]      idx_q;
    logic [CW-1:0]      cnt_q;
    logic [DW-1:0]      rem_q;
    logic [Q-1:0]       dvd_q;
    logic [Q-1:0]       quo_q;
    logic [CH*GW-1:0]   gain_sh_q;
    logic [CH-1:0]      zero_sh_q;
    logic [CH-1:0]      sat_sh_q;
    logic [CH*GW-1:0]   gain_q;
    logic [CH-1:0]      zero_q;
    logic [CH-1:0]      sat_q;
    logic               valid_q;

    logic [SW-1:0]      sum_d;
    logic [DW-1:0]      tgt_d;
    logic [DW-1:0]      divisor;
    logic [DW:0]        trial;
    logic               ge;
    logic [DW-1:0]      rem_d;
    logic [GW+1:0]      res;
    logic [CH*GW-1:0]   gain_sh_d;
    logic [CH-1:0]      zero_sh_d;
    logic [CH-1:0]      sat_sh_d;

    // Result for one channel packed as {sat, zero, gain}; a zero mean wins over saturation.
    function automatic logic [GW+1:0] resolve(input logic [Q-1:0] quo, input logic [DW-1:0] dv);
        logic [QX-1:0] qx;
        qx = QX'(quo);
        if (dv == '0)
            return {1'b0, 1'b1, ONE};
        else if ((qx >> GW) != '0)
            return {1'b1, 1'b0, GMAX};
        else
            return {2'b00, qx[GW-1:0]};
    endfunction

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < CH; k++)
            sum_d = sum_d + SW'(mean_q[k*DW +: DW]);
        if (mode_q)
            tgt_d = mean_q[REF_CH*DW +: DW];
        else
            tgt_d = DW'(sum_d / SW'(CH));
    end

    // Restoring divider step: shift in the next dividend bit, subtract when it fits.
    assign divisor = mean_q[idx_q*DW +: DW];
    assign trial   = {rem_q, dvd_q[Q-1]};
    assign ge      = (trial >= {1'b0, divisor});

    always_comb begin
        rem_d = trial[DW-1:0];
        if (ge)
            rem_d = DW'(trial - {1'b0, divisor});
    end

    always_comb begin
        res       = resolve(quo_q, divisor);
        gain_sh_d = gain_sh_q;
        zero_sh_d = zero_sh_q;
        sat_sh_d  = sat_sh_q;
        gain_sh_d[idx_q*GW +: GW] = res[GW-1:0];
        zero_sh_d[idx_q]          = res[GW];
        sat_sh_d[idx_q]           = res[GW+1];
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start_i) begin
            mode_q <= mode_i;
            mean_q <= mean_i;
        end
        if (state_q == S_TGT)
            tgt_q <= tgt_d;
        if (state_q == S_STORE) begin
            gain_sh_q <= gain_sh_d;
            zero_sh_q <= zero_sh_d;
            sat_sh_q  <= sat_sh_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            valid_q <= 1'b0;
            gain_q  <= {CH{ONE}};
            zero_q  <= '0;
            sat_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i)
                        state_q <= S_TGT;
                end
                S_TGT: begin
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    quo_q   <= '0;
                    dvd_q   <= {tgt_d, {FRAC{1'b0}}};
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[Q-2:0], ge};
                    dvd_q <= dvd_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(Q - 1))
                        state_q <= S_STORE;
                end
                S_STORE: begin
                    if (idx_q == IW'(CH - 1)) begin
                        // Last channel: publish the whole set, including the slot written this cycle.
                        gain_q  <= gain_sh_d;
                        zero_q  <= zero_sh_d;
                        sat_q   <= sat_sh_d;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        dvd_q   <= {tgt_q, {FRAC{1'b0}}};
                        state_q <= S_DIV;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = ~ready_o;
    assign valid_o = valid_q;
    assign gain_o  = gain_q;
    assign zero_o  = zero_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_wb_gain_calc.sv
// Bench for wb_gain_calc: a default instance and a GW=12 instance share stimulus;
// results are compared to a plain-arithmetic reference model.
module tb_wb_gain_calc;

    localparam int DW     = 8;
    localparam int CH     = 3;
    localparam int FRAC   = 8;
    localparam int REF_CH = 1;
    localparam int LAT    = 53;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [23:0] mean;

    logic        ready_a, busy_a, valid_a;
    logic [47:0] gain_a;
    logic [2:0]  zero_a, sat_a;
    logic        ready_b, busy_b, valid_b;
    logic [35:0] gain_b;
    logic [2:0]  zero_b, sat_b;

    int tests = 0;
    int fails = 0;

    logic [47:0] prev_ga;

    always #5 clk = ~clk;

    wb_gain_calc u_a (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .mean_i(mean),
        .ready_o(ready_a), .busy_o(busy_a), .valid_o(valid_a),
        .gain_o(gain_a), .zero_o(zero_a), .sat_o(sat_a)
    );

    wb_gain_calc #(.GW(12)) u_b (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .mean_i(mean),
        .ready_o(ready_b), .busy_o(busy_b), .valid_o(valid_b),
        .gain_o(gain_b), .zero_o(zero_b), .sat_o(sat_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Gains from the rules directly: target level, then truncated T*2^FRAC/mean per channel.
    function automatic void model(input logic md, input logic [23:0] m, input int gw,
                                  output logic [47:0] g, output logic [2:0] z, output logic [2:0] s);
        longint t, q, mk, lim;
        g = '0; z = '0; s = '0;
        lim = longint'(1) << gw;
        if (md) t = m[REF_CH*DW +: DW];
        else    t = (longint'(m[7:0]) + longint'(m[15:8]) + longint'(m[23:16])) / CH;
        for (int k = 0; k < CH; k++) begin
            mk = m[k*DW +: DW];
            if (mk == 0) begin
                q = longint'(1) << FRAC;
                z[k] = 1'b1;
            end else begin
                q = (t << FRAC) / mk;
                if (q >= lim) begin
                    q = lim - 1;
                    s[k] = 1'b1;
                end
            end
            g = g | (48'(q) << (k * gw));
        end
    endfunction

    task automatic check_set(input string tag, input logic md, input logic [23:0] m);
        logic [47:0] ga, gb;
        logic [2:0]  za, sa, zb, sb;
        model(md, m, 16, ga, za, sa);
        model(md, m, 12, gb, zb, sb);
        chk({tag, "_gain16"}, gain_a, ga);
        chk({tag, "_zero16"}, zero_a, za);
        chk({tag, "_sat16"},  sat_a,  sa);
        chk({tag, "_gain12"}, gain_b, gb[35:0]);
        chk({tag, "_zero12"}, zero_b, zb);
        chk({tag, "_sat12"},  sat_b,  sb);
        prev_ga = ga;
    endtask

    // One request; optional start pulse while busy and optional reset abort at a given cycle.
    task automatic run(input string tag, input logic md, input logic [23:0] m,
                       input int busy_at, input int abort_at);
        int cyc;
        bit seen;
        @(negedge clk);
        chk({tag, "_ready_pre"}, ready_a, 1'b1);
        start = 1'b1; mode = md; mean = m;
        @(posedge clk);
        cyc = 0; seen = 0;
        while (cyc < 120 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                mean  = 24'($urandom);
                mode  = ~md;
            end
            if (busy_at > 0 && cyc == busy_at)     start = 1'b1;
            if (busy_at > 0 && cyc == busy_at + 1) start = 1'b0;
            if (abort_at > 0 && cyc == abort_at)     rst = 1'b1;
            if (abort_at > 0 && cyc == abort_at + 1) rst = 1'b0;
            if (cyc == 20 && abort_at == 0) begin
                chk({tag, "_busy"}, {ready_a, busy_a}, 2'b01);
                chk({tag, "_hold_mid"}, gain_a, prev_ga);
            end
            if (valid_a) seen = 1;
        end
        if (abort_at > 0) begin
            chk({tag, "_abort_novalid"}, seen, 1'b0);
            chk({tag, "_abort_gain"}, gain_a, {3{16'h0100}});
            chk({tag, "_abort_flags"}, {zero_a, sat_a, ready_a}, 7'b0000001);
            prev_ga = {3{16'h0100}};
        end else begin
            chk({tag, "_latency"}, cyc, LAT);
            chk({tag, "_valid12"}, valid_b, 1'b1);
            check_set(tag, md, m);
            @(negedge clk);
            chk({tag, "_pulse"}, {valid_a, ready_a}, 2'b01);
            chk({tag, "_hold_after"}, gain_a, prev_ga);
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [23:0] m;
        rst = 1'b1; start = 1'b0; mode = 1'b0; mean = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gain16", gain_a, {3{16'h0100}});
        chk("reset_gain12", gain_b, {3{12'h100}});
        chk("reset_ctrl", {ready_a, busy_a, valid_a, zero_a, sat_a}, 9'b100_000_000);
        rst = 1'b0;
        prev_ga = {3{16'h0100}};

        run("m0_basic", 1'b0, {8'd32, 8'd128, 8'd64}, 0, 0);
        chk("m0_basic_const", gain_a, {16'h0250, 16'h0094, 16'h0128});
        run("m1_ref", 1'b1, {8'd32, 8'd128, 8'd64}, 0, 0);
        chk("m1_ref_const", gain_a, {16'h0400, 16'h0100, 16'h0200});
        run("m0_zero", 1'b0, {8'd100, 8'd100, 8'd0}, 0, 0);
        chk("m0_zero_const", {gain_a, zero_a}, {16'h00A8, 16'h00A8, 16'h0100, 3'b001});
        run("m0_sat", 1'b0, {8'd255, 8'd255, 8'd1}, 0, 0);
        chk("m0_sat_const12", {gain_b, sat_b}, {12'h0AA, 12'h0AA, 12'hFFF, 3'b001});
        run("busy_start", 1'b0, {8'd32, 8'd128, 8'd64}, 10, 0);
        run("abort", 1'b0, {8'd10, 8'd20, 8'd30}, 0, 30);
        run("after_abort", 1'b1, {8'd40, 8'd50, 8'd60}, 0, 0);

        // Back-to-back: start held through DONE is re-accepted from IDLE.
        m = {8'd90, 8'd45, 8'd200};
        @(negedge clk);
        start = 1'b1; mode = 1'b0; mean = m;
        cyc = 0; seen = 0;
        while (cyc < 120 && !seen) begin
            @(negedge clk);
            cyc++;
            if (valid_a) seen = 1;
        end
        chk("b2b_first_valid", seen, 1'b1);
        check_set("b2b_first", 1'b0, m);
        @(negedge clk);
        chk("b2b_idle", ready_a, 1'b1);
        @(negedge clk);
        chk("b2b_reaccept", ready_a, 1'b0);
        start = 1'b0;
        cyc = 1; seen = 0;
        while (cyc < 120 && !seen) begin
            @(negedge clk);
            cyc++;
            if (valid_a) seen = 1;
        end
        chk("b2b_latency", cyc, LAT);
        check_set("b2b_second", 1'b0, m);

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < CH; k++)
                m[k*DW +: DW] = ($urandom_range(0, 5) == 0) ? 8'd0
                              : (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4)) : 8'($urandom));
            run("rand", 1'($urandom_range(0, 1)), m, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_gain_calc.md
WB_GAIN_CALC -- requirements
Module: wb_gain_calc

Interface
REQ-001 Parameter: DW, 8, bit width of each channel mean.
REQ-002 Parameter: CH, 3, channel count (≥2); channel k is packed at bits [k*DW +: DW].
REQ-003 Parameter: FRAC, 8, fractional bits of each gain; unity gain = 2^FRAC.
REQ-004 Parameter: GW, 16, width of each gain word (GW > FRAC).
REQ-005 Parameter: REF_CH, 1, reference channel index used in mode 1.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; one clock, all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- start_i, in, 1, request a computation; accepted only when ready_o=1.
- mode_i, in, 1, 0 = gray-world target, 1 = reference-channel target; sampled on accept.
- mean_i, in, CH*DW, channel means; sampled on accept.
- ready_o, out, 1, high only in IDLE.
- busy_o, out, 1, equal to ~ready_o.
- valid_o, out, 1, one-cycle pulse when a new gain set is presented.
- gain_o, out, CH*GW, per-channel gains in unsigned Q(GW-FRAC).FRAC format, packed like mean_i.
- zero_o, out, CH, per channel: mean was 0 in the last completed set.
- sat_o, out, CH, per channel: quotient was clamped in the last completed set.

Function
REQ-007 The FSM shall have states IDLE, TGT, DIV, STORE and DONE.
REQ-008 IDLE->TGT when start_i=1. On that edge the block shall register mean_i and mode_i into internal copies.
REQ-009 TGT shall last 1 cycle and compute T.
- mode 0: T = floor(sum of all means / CH); the sum is CH*DW-wide enough without overflow.
- mode 1: T = mean[REF_CH].
- Channel index is cleared to 0.
REQ-010 DIV shall run an unsigned restoring divider shared across channels.
- Dividend = T * 2^FRAC, divisor = mean[idx].
- Exactly Q = DW+FRAC cycles, one quotient bit per cycle, MSB first.
REQ-011 STORE shall last 1 cycle.
- Write a shadow result for channel idx.
- idx<CH-1: increment idx, go to DIV. idx=CH-1: go to DONE.
REQ-012 Shadow result rules, applied in this priority order:
- mean=0: gain = 2^FRAC, zero=1, sat=0. DIV still consumes Q cycles.
- quotient ≥ 2^GW: gain = 2^GW-1, sat=1.
- otherwise: gain = quotient[GW-1:0].
REQ-013 DONE shall last 1 cycle and then go to IDLE.
- In DONE, gain_o, zero_o and sat_o shall update together from the shadow registers.
- valid_o shall be 1 only in DONE.
REQ-014 Latency shall be fixed. valid_o asserts exactly 2 + CH*(Q+1) cycles after the accept edge (53 cycles at the defaults), independent of data values.
REQ-015 start_i while busy_o=1 shall be ignored, with no effect on the running computation or its result.
REQ-016 gain_o, zero_o and sat_o shall hold their values between DONE cycles; partial results shall never be visible.
REQ-017 Back-to-back requests shall be supported: start_i held high is re-accepted on the first cycle after DONE, in IDLE.
REQ-018 Truncation only, no rounding, in both the T computation and the quotient.

Reset
REQ-019 While rst=1 at a clock edge, the block shall enter IDLE and drive:
- ready_o=1, busy_o=0, valid_o=0.
- every gain_o word = 2^FRAC; zero_o=0; sat_o=0.
- idx=0; divider registers cleared.
REQ-020 rst asserted mid-computation shall abort it. No valid_o pulse is produced for the aborted request, and outputs return to the reset values in REQ-019.

Verification
REQ-021 Reset check: after reset, gain_o = {0x0100,0x0100,0x0100}, ready_o=1, valid_o=0.
REQ-022 Mode 0, means R=64, G=128, B=32.
- Required: T=74; gains R=0x0128, G=0x0094, B=0x0250.
- valid_o exactly 53 cycles after accept; zero_o=0, sat_o=0.
REQ-023 Mode 1, REF_CH=1, means 64/128/32.
- Required: gains 0x0200 / 0x0100 / 0x0400.
REQ-024 Mode 0, means 0/100/100.
- Required: T=66; gains 0x0100 / 0x00A8 / 0x00A8; zero_o=3'b001.
REQ-025 Instance with GW=12, mode 0, means 1/255/255.
- Required: T=170; gain R=0xFFF, sat_o=3'b001.
- G and B gains = 0x0AA (170).
REQ-026 Busy-start and abort.
- start_i pulsed 10 cycles after an accept: result and timing unchanged.
- rst asserted at cycle 30 of a run: no valid_o pulse, gains = 0x0100; a new request afterwards completes normally.
